// File: rtl/btn_debounce_pkg.sv
// Shared constants and state encoding for the push-button debouncer.
// The counter top reuses the default divider settings from here.
package btn_debounce_pkg;

  localparam int unsigned TickDivDefault = 1_000_000;  // 10 ms at 100 MHz
  localparam int unsigned TickWDefault   = 20;

  typedef enum logic [2:0] {
    StZero   = 3'd0,
    StWait11 = 3'd1,
    StWait12 = 3'd2,
    StWait13 = 3'd3,
    StOne    = 3'd4,
    StWait01 = 3'd5,
    StWait02 = 3'd6,
    StWait03 = 3'd7
  } state_e;

endpackage

// File: rtl/btn_debounce_if.sv
// Button-side signal bundle: raw button in, debounced level and press tick out.
interface btn_debounce_if;

  logic btn;
  logic db_level;
  logic tick;

  modport master (
    output btn,
    input  db_level,
    input  tick
  );

  modport slave (
    input  btn,
    output db_level,
    output tick
  );

endinterface

// File: rtl/btn_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module btn_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, free-running sample divider and a
// three-sample stability FSM that emits one registered tick per accepted press.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault,
  parameter int unsigned TICK_W   = TickWDefault
) (
  input logic           clk,
  input logic           reset,
  btn_debounce_if.slave bus
);

  localparam logic [TICK_W-1:0] DivLast = TICK_W'(TICK_DIV - 1);

  logic              btn_s;
  logic [TICK_W-1:0] div_q, div_d;
  logic              m_tick;
  state_e            state_q, state_d;
  logic              db_level_q;
  logic              tick_q;

  btn_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn),
    .q     (btn_s)
  );

  // Divider free-runs; button activity never restarts it.
  assign m_tick = (div_q == DivLast);
  assign div_d  = m_tick ? '0 : div_q + TICK_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // In every WAIT state a level change outranks a coinciding sample tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StZero:   if (btn_s)  state_d = StWait11;
      StWait11: if (!btn_s) state_d = StZero; else if (m_tick) state_d = StWait12;
      StWait12: if (!btn_s) state_d = StZero; else if (m_tick) state_d = StWait13;
      StWait13: if (!btn_s) state_d = StZero; else if (m_tick) state_d = StOne;
      StOne:    if (!btn_s) state_d = StWait01;
      StWait01: if (btn_s)  state_d = StOne;  else if (m_tick) state_d = StWait02;
      StWait02: if (btn_s)  state_d = StOne;  else if (m_tick) state_d = StWait03;
      StWait03: if (btn_s)  state_d = StOne;  else if (m_tick) state_d = StZero;
      default:  state_d = StZero;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StZero;
      db_level_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_level_q <= (state_d == StOne) || (state_d == StWait01) ||
                    (state_d == StWait02) || (state_d == StWait03);
      tick_q     <= (state_q == StWait13) && (state_d == StOne);
    end
  end

  assign bus.db_level = db_level_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized and directed bench for btn_debounce with a behavioural press/release model.
module tb_btn_debounce;
  import btn_debounce_pkg::*;

  localparam int unsigned Div = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  btn_debounce_if bus ();

  btn_debounce #(
    .TICK_DIV (Div),
    .TICK_W   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: a level change is accepted once the synchronized level has
  // disagreed with the debounced level across three consecutive sample ticks.
  logic exp_s1, exp_s2, exp_db, exp_pend, exp_tick;
  int   exp_phase, exp_k;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_s1 <= 0; exp_s2 <= 0; exp_db <= 0; exp_pend <= 0; exp_tick <= 0;
      exp_phase <= 0; exp_k <= 0;
    end else begin
      exp_s1    <= bus.btn;
      exp_s2    <= exp_s1;
      exp_phase <= (exp_phase + 1) % Div;
      exp_tick  <= 1'b0;
      if (!exp_pend) begin
        if (exp_s2 != exp_db) begin
          exp_pend <= 1'b1;
          exp_k    <= 0;
        end
      end else if (exp_s2 == exp_db) begin
        exp_pend <= 1'b0;
      end else if (exp_phase == Div - 1) begin
        if (exp_k == 2) begin
          exp_db   <= !exp_db;
          exp_pend <= 1'b0;
          exp_tick <= !exp_db;
        end else begin
          exp_k <= exp_k + 1;
        end
      end
    end
  end

  task automatic settle();
    bus.btn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    int ticks = 0;
    bus.btn = 1'b1;
    reset   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.db_level !== 1'b0 || bus.tick !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d db_level=%b tick=%b required 0/0",
                 i, bus.db_level, bus.tick);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) ticks++;
      total++;
      if (bus.tick !== exp_tick || bus.db_level !== exp_db) begin
        bad++;
        $display("FAIL reset_release cyc=%0d tick=%b db=%b required %b/%b",
                 i, bus.tick, bus.db_level, exp_tick, exp_db);
      end
    end
    total++;
    if (ticks != 1) begin
      bad++;
      $display("FAIL reset_release_ticks got=%0d required 1", ticks);
    end
  endtask

  task automatic test_clean_press();
    int ticks = 0;
    int first = -1;
    settle();
    bus.btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
      total++;
      if (bus.tick !== exp_tick || bus.db_level !== exp_db) begin
        bad++;
        $display("FAIL clean_press cyc=%0d tick=%b db=%b required %b/%b",
                 i, bus.tick, bus.db_level, exp_tick, exp_db);
      end
    end
    total++;
    if (ticks != 1) begin
      bad++;
      $display("FAIL clean_press_ticks got=%0d required 1", ticks);
    end
    // Two sync edges plus one edge into WAIT1_1, then 8..12 cycles.
    total++;
    if (first < 11 || first > 15) begin
      bad++;
      $display("FAIL clean_press_latency got=%0d required 11..15", first);
    end
    total++;
    if (bus.db_level !== 1'b1) begin
      bad++;
      $display("FAIL clean_press_level got=%b required 1", bus.db_level);
    end
  endtask

  task automatic test_bounce();
    int ticks_bounce = 0;
    int ticks_hold = 0;
    settle();
    for (int i = 0; i < 12; i++) begin
      bus.btn = ((i / 3) % 2 == 0);
      @(negedge clk);
      if (bus.tick === 1'b1) ticks_bounce++;
      total++;
      if (bus.tick !== exp_tick || bus.db_level !== exp_db) begin
        bad++;
        $display("FAIL bounce cyc=%0d tick=%b db=%b required %b/%b",
                 i, bus.tick, bus.db_level, exp_tick, exp_db);
      end
    end
    bus.btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) ticks_hold++;
      total++;
      if (bus.tick !== exp_tick || bus.db_level !== exp_db) begin
        bad++;
        $display("FAIL bounce_hold cyc=%0d tick=%b db=%b required %b/%b",
                 i, bus.tick, bus.db_level, exp_tick, exp_db);
      end
    end
    total++;
    if (ticks_bounce != 0 || ticks_hold != 1) begin
      bad++;
      $display("FAIL bounce_ticks during=%0d after=%0d required 0/1", ticks_bounce, ticks_hold);
    end
  endtask

  task automatic test_release_bounce();
    int ticks = 0;
    int fall = -1;
    total++;
    if (bus.db_level !== 1'b1) begin
      bad++;
      $display("FAIL rel_bounce_start db=%b required 1", bus.db_level);
    end
    bus.btn = 1'b0;
    repeat (2) @(negedge clk);
    bus.btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) ticks++;
      total++;
      if (bus.db_level !== 1'b1 || bus.tick !== 1'b0) begin
        bad++;
        $display("FAIL rel_glitch cyc=%0d db=%b tick=%b required 1/0",
                 i, bus.db_level, bus.tick);
      end
    end
    bus.btn = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) ticks++;
      if (fall < 0 && bus.db_level === 1'b0) fall = i;
    end
    total++;
    if (fall < 11 || fall > 15 || ticks != 0) begin
      bad++;
      $display("FAIL release_latency fall=%0d ticks=%0d required 11..15 and 0", fall, ticks);
    end
  endtask

  task automatic test_reset_mid();
    int ticks = 0;
    int first = -1;
    bit found = 0;
    settle();
    bus.btn = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (exp_pend && exp_k == 1) found = 1;
    end
    total++;
    if (!found || dut.state_q !== StWait12) begin
      bad++;
      $display("FAIL mid_reach found=%0d state=%0d required WAIT1_2", found, dut.state_q);
    end
    reset = 1'b0;
    #1;
    total++;
    if (dut.state_q !== StZero || bus.tick !== 1'b0 || bus.db_level !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset state=%0d tick=%b db=%b required 0/0/0",
               dut.state_q, bus.tick, bus.db_level);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (ticks != 1 || first < 11 || first > 15) begin
      bad++;
      $display("FAIL mid_restart ticks=%0d at=%0d required 1 at 11..15", ticks, first);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    settle();
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        bus.btn = $urandom_range(0, 1);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30) : $urandom_range(1, 8);
      end
      hold--;
      @(negedge clk);
      total++;
      if (bus.tick !== exp_tick || bus.db_level !== exp_db) begin
        bad++;
        $display("FAIL random cyc=%0d btn=%b tick=%b db=%b required %b/%b",
                 i, bus.btn, bus.tick, bus.db_level, exp_tick, exp_db);
      end
    end
  endtask

  task automatic test_counter();
    logic [7:0] cnt8 = 8'h00;
    settle();
    for (int p = 1; p <= 257; p++) begin
      for (int h = 0; h < 32; h++) begin
        bus.btn = (h < 16);
        @(negedge clk);
        if (bus.tick === 1'b1) cnt8 = cnt8 + 8'h01;
        total++;
        if (bus.tick !== exp_tick) begin
          bad++;
          $display("FAIL counter_tick press=%0d tick=%b required %b", p, bus.tick, exp_tick);
        end
      end
      if (p == 5) begin
        total++;
        if (cnt8 !== 8'h05) begin
          bad++;
          $display("FAIL counter_five got=%h required 05", cnt8);
        end
      end
    end
    total++;
    if (cnt8 !== 8'h01) begin
      bad++;
      $display("FAIL counter_wrap got=%h required 01", cnt8);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.btn = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_reset_mid();
    test_random();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debouncer and one-pulse generator for a mechanical push-button. Feeds the 8-bit step counter in the button/counter top: it synchronizes the raw button, rejects bounce with a sampled-stability state machine, and emits exactly one single-cycle `tick` per accepted press.

## Interface
- `TICK_DIV`, 1_000_000: `clk` cycles per sample tick; 10 ms at 100 MHz; must be ≥ 2.
- `TICK_W`, 20: sample-divider width; must satisfy 2^TICK_W ≥ TICK_DIV.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `btn`  in  1  raw, asynchronous, bouncing button level; 1 = pressed.
- `db_level`  out  1  debounced button level.
- `tick`  out  1  one-cycle pulse per accepted press, to the counter's clock-enable input.

## Operation
- Synchronizer: 2-FF chain `btn` → `btn_s`. Both FFs reset to 0.
- Sample divider: free-running count 0 .. TICK_DIV-1, wrapping to 0. `m_tick` = 1 for one cycle while the count equals TICK_DIV-1. Runs continuously and is never restarted by button activity.
- FSM states: ZERO, WAIT1_1, WAIT1_2, WAIT1_3, ONE, WAIT0_1, WAIT0_2, WAIT0_3. Reset state is ZERO.
- Transitions:
  - ZERO: `btn_s`=1 → WAIT1_1.
  - WAIT1_k: `btn_s`=0 → ZERO (takes priority over `m_tick`). Otherwise `m_tick` → WAIT1_(k+1). From WAIT1_3, `m_tick` → ONE.
  - ONE: `btn_s`=0 → WAIT0_1.
  - WAIT0_k: `btn_s`=1 → ONE (takes priority). Otherwise `m_tick` → WAIT0_(k+1). From WAIT0_3, `m_tick` → ZERO.
  - No `m_tick` and no level change: hold state.
- `db_level`: registered. 1 in ONE and WAIT0_1..3; 0 otherwise.
- `tick`: registered. Set to 1 only on the edge where the state goes WAIT1_3 → ONE; 0 on every other edge.
- No tick on release.
- Holding the button indefinitely produces no repeat ticks.

## Timing
- Reset values: `db_level`=0, `tick`=0, state ZERO, divider 0, synchronizer 0.
- Assertion of `reset` mid-operation immediately forces all of the above, including aborting a WAIT state. No `tick` is emitted during or on release of reset.
- Synchronizer latency: 2 cycles.
- Press acceptance:
  - `btn_s` must stay 1 across three consecutive `m_tick`s.
  - `tick` and `db_level` rise on the same edge.
  - That edge falls between 2·TICK_DIV and 3·TICK_DIV cycles after the FSM enters WAIT1_1.
- Release acceptance: symmetric. `db_level` falls 2·TICK_DIV to 3·TICK_DIV cycles after entering WAIT0_1.
- Bounce: any 0-glitch during WAIT1_* returns to ZERO. Qualification restarts from scratch on the next 1.
- `m_tick` coinciding with a level change in a WAIT state: the level change wins.
- `tick` is high for exactly 1 cycle and is never high on two consecutive cycles.
- Minimum spacing between two ticks: one full release qualification plus one full press qualification.

## Structure
- Shared package `btn_debounce_pkg`: 3-bit state encoding localparams (ZERO=0 … WAIT0_3=7) and the default TICK_DIV / TICK_W constants. The counter top also uses these defaults.
- One sub-module: `btn_sync_2ff` (2-FF synchronizer, async active-low reset to 0).
- Divider, FSM and output registers live in `btn_debounce`.

## Test plan
Sim setup: TICK_DIV=4, TICK_W=3.
- Reset: hold `reset`=0 for 5 cycles with `btn`=1 → `db_level`=0 and `tick`=0 throughout. After release, the normal press sequence follows with exactly one tick.
- Clean press: `btn` 0→1, held for 40 cycles → exactly one `tick` pulse, 1 cycle wide. `db_level` rises on that edge, 8–12 cycles after entry to WAIT1_1. No further ticks while held.
- Bounce: `btn` toggles 1,0,1,0 every 3 cycles for 12 cycles, then holds 1 → no tick during the bounce. One tick after stable qualification. Total tick count = 1.
- Release bounce: from ONE, `btn` glitches to 0 for 2 cycles, then 1 → `db_level` stays 1 and no tick. A later clean release drops `db_level` after 8–12 cycles with no tick.
- Reset mid-qualification: assert `reset` while in WAIT1_2 → state ZERO, `tick`=0. With `btn` still held after release, qualification restarts and one tick appears 8–12 cycles after re-entering WAIT1_1.
- Counter integration: 5 qualified presses drive the 8-bit counter from 0x00 to 0x05. 255+2 presses wrap it to 0x01.
